// File: rtl/block_xfer_ctrl.sv
// Block-transfer controller: copies BLOCK_WORDS words between main memory and disk.
// Define XFER_CHECKSUM_EN to build the running XOR checksum of the written block on csum.
module block_xfer_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned P_ADDR_W    = 16,
    parameter int unsigned S_ADDR_W    = 15,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                dir,
    input  logic [P_ADDR_W-1:0] p_base,
    input  logic [S_ADDR_W-1:0] s_base,
    output logic                waitTR,
    output logic                done,
    output logic                err,
    output logic [P_ADDR_W-1:0] addr_p,
    output logic [DATA_W-1:0]   data_p,
    output logic                tr_p,
    input  logic [DATA_W-1:0]   q_p,
    output logic [S_ADDR_W-1:0] addr_s,
    output logic [DATA_W-1:0]   data_s,
    output logic                tr_s,
    input  logic [DATA_W-1:0]   q_s,
    output logic [DATA_W-1:0]   csum
);
    localparam int unsigned IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e              state_q, state_d;
    logic                dir_q, dir_d;
    logic [P_ADDR_W-1:0] p_base_q, p_base_d;
    logic [S_ADDR_W-1:0] s_base_q, s_base_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [P_ADDR_W-1:0] addr_p_q;
    logic [S_ADDR_W-1:0] addr_s_q;
    logic                err_q, err_d;
    logic [P_ADDR_W-1:0] p_cur;
    logic [S_ADDR_W-1:0] s_cur;

    assign p_cur = p_base_q + P_ADDR_W'(idx_q);
    assign s_cur = s_base_q + S_ADDR_W'(idx_q);
    assign err   = err_q;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        p_base_d = p_base_q;
        s_base_d = s_base_q;
        idx_d    = idx_q;
        err_d    = start && (state_q != StIdle);
        waitTR   = (state_q != StIdle);
        done     = 1'b0;
        tr_p     = 1'b0;
        tr_s     = 1'b0;
        data_p   = '0;
        data_s   = '0;
        // Addresses hold their last driven value unless a phase drives them.
        addr_p   = addr_p_q;
        addr_s   = addr_s_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dir_d    = dir;
                    p_base_d = p_base;
                    s_base_d = s_base;
                    idx_d    = '0;
                    state_d  = StRead;
                end
            end
            StRead: begin
                if (dir_q) addr_s = s_cur;
                else       addr_p = p_cur;
                state_d = StWrite;
            end
            StWrite: begin
                if (dir_q) begin
                    addr_p = p_cur;
                    data_p = q_s;
                    tr_p   = 1'b1;
                end else begin
                    addr_s = s_cur;
                    data_s = q_p;
                    tr_s   = 1'b1;
                end
                if (idx_q == IDX_W'(BLOCK_WORDS - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StRead;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            dir_q    <= 1'b0;
            p_base_q <= '0;
            s_base_q <= '0;
            idx_q    <= '0;
            addr_p_q <= '0;
            addr_s_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            p_base_q <= p_base_d;
            s_base_q <= s_base_d;
            idx_q    <= idx_d;
            addr_p_q <= addr_p;
            addr_s_q <= addr_s;
            err_q    <= err_d;
        end
    end

`ifdef XFER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == StIdle && start) begin
            csum_d = '0;
        end else if (state_q == StWrite) begin
            csum_d = csum_q ^ (dir_q ? q_s : q_p);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_block_xfer_ctrl.sv
// Self-checking bench for block_xfer_ctrl: memory models, write scoreboard, vector table.
// Honours XFER_CHECKSUM_EN to pick the expected csum behaviour.
module tb_block_xfer_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, dir;
    logic [15:0] p_base;
    logic [14:0] s_base;
    logic        waitTR, done, err, tr_p, tr_s;
    logic [15:0] addr_p, data_p, q_p, data_s, q_s, csum;
    logic [14:0] addr_s;

    always #5 clk = ~clk;

    block_xfer_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dir    (dir),
        .p_base (p_base),
        .s_base (s_base),
        .waitTR (waitTR),
        .done   (done),
        .err    (err),
        .addr_p (addr_p),
        .data_p (data_p),
        .tr_p   (tr_p),
        .q_p    (q_p),
        .addr_s (addr_s),
        .data_s (data_s),
        .tr_s   (tr_s),
        .q_s    (q_s),
        .csum   (csum)
    );

    // Synchronous-read memories; the ld_* port lets the bench preload them.
    logic [15:0] mem_p [0:65535];
    logic [15:0] mem_s [0:32767];
    logic        ld_en;
    logic [15:0] ld_pa, ld_pd, ld_sd;
    logic [14:0] ld_sa;

    always @(posedge clk) begin
        q_p <= mem_p[addr_p];
        q_s <= mem_s[addr_s];
        if (tr_p) mem_p[addr_p] <= data_p;
        if (tr_s) mem_s[addr_s] <= data_s;
        if (ld_en) begin
            mem_p[ld_pa] <= ld_pd;
            mem_s[ld_sa] <= ld_sd;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int t0 = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        is_p;
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] cyc;
    } exp_t;

    typedef struct packed {
        logic            dir;
        logic [15:0]     pb;
        logic [14:0]     sb;
        logic [7:0][15:0] w;
    } vec_t;

    exp_t sb_q[$];

    // Every destination write is popped from the scoreboard and checked.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (tr_p || tr_s) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        m = sb_q.pop_front();
                        check("wr_port_p", 32'(tr_p), 32'(m.is_p));
                        check("wr_port_s", 32'(tr_s), 32'(!m.is_p));
                        check("wr_addr", 32'(m.is_p ? addr_p : {1'b0, addr_s}), 32'(m.addr));
                        check("wr_data", 32'(m.is_p ? data_p : data_s), 32'(m.data));
                        check("wr_cycle", cyc - t0, m.cyc);
                    end
                end else begin
                    check("idle_data_zero", {data_p, data_s}, 32'd0);
                end
            end
        end
    end

    task automatic run(input vec_t v, input int busy_at, input int rst_at);
        int          nw, done_cnt, done_c, err_cnt, err_c, wait_bad, lastc;
        logic [15:0] xs, cs_done, pa;
        logic [14:0] sa;
        exp_t        e;
        nw       = (rst_at > 0) ? (rst_at - 1) / 2 : 8;
        lastc    = (rst_at > 0) ? rst_at : 17;
        xs       = '0;
        cs_done  = '0;
        done_cnt = 0;
        done_c   = -1;
        err_cnt  = 0;
        err_c    = -1;
        wait_bad = 0;
        for (int k = 0; k < 8; k++) begin
            pa = v.pb + 16'(k);
            sa = v.sb + 15'(k);
            @(negedge clk);
            ld_en = 1'b1;
            ld_pa = pa;
            ld_sa = sa;
            ld_pd = v.dir ? 16'hDEAD : v.w[k];
            ld_sd = v.dir ? v.w[k] : 16'hDEAD;
            if (k < nw) begin
                e.is_p = v.dir;
                e.addr = v.dir ? pa : {1'b0, sa};
                e.data = v.w[k];
                e.cyc  = 32'(2 * k + 2);
                sb_q.push_back(e);
            end
            xs = xs ^ v.w[k];
        end
        @(negedge clk);
        ld_en  = 1'b0;
        start  = 1'b1;
        dir    = v.dir;
        p_base = v.pb;
        s_base = v.sb;
        t0     = cyc;
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) begin
                if (done) begin
                    done_cnt++;
                    done_c  = c;
                    cs_done = csum;
                end
                if (err) begin
                    err_cnt++;
                    err_c = c;
                end
                if (waitTR !== (c <= lastc)) wait_bad++;
                // A start while busy carries garbage fields that must be ignored.
                start  = (c == busy_at);
                dir    = (c == busy_at) ? ~v.dir : v.dir;
                p_base = (c == busy_at) ? 16'hBEEF : v.pb;
                s_base = (c == busy_at) ? 15'h1357 : v.sb;
                rst    = (c == rst_at);
            end
            @(negedge clk);
        end
        check("done_count", done_cnt, (rst_at > 0) ? 0 : 1);
        if (rst_at == 0) check("done_cycle", done_c, 17);
        check("err_count", err_cnt, (busy_at > 0) ? 1 : 0);
        if (busy_at > 0) check("err_cycle", err_c, busy_at + 1);
        check("waitTR_profile", wait_bad, 0);
        check("writes_outstanding", sb_q.size(), 0);
        sb_q.delete();
`ifdef XFER_CHECKSUM_EN
        if (rst_at == 0) check("csum_at_done", 32'(cs_done), 32'(xs));
        check("csum_hold", 32'(csum), (rst_at > 0) ? 32'd0 : 32'(xs));
`else
        if (rst_at == 0) check("csum_at_done", 32'(cs_done), 32'd0);
        check("csum_tied", 32'(csum), 32'd0);
`endif
        for (int k = 0; k < 8; k++) begin
            pa = v.pb + 16'(k);
            sa = v.sb + 15'(k);
            check("dest_word", 32'(v.dir ? mem_p[pa] : mem_s[sa]),
                  32'((k < nw) ? v.w[k] : 16'hDEAD));
        end
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0].dir = 1'b0; vecs[0].pb = 16'h0010; vecs[0].sb = 15'h0100;
        vecs[1].dir = 1'b1; vecs[1].pb = 16'hFFFE; vecs[1].sb = 15'h7FFC;
        vecs[2].dir = 1'b0; vecs[2].pb = 16'h0200; vecs[2].sb = 15'h0300;
        vecs[3].dir = 1'b1; vecs[3].pb = 16'h1234; vecs[3].sb = 15'h0ABC;
        for (int k = 0; k < 8; k++) begin
            vecs[0].w[k] = 16'(32'h1111 * k);
            vecs[1].w[k] = 16'(32'hA000 + 32'h0101 * k);
            vecs[2].w[k] = 16'(k + 1);
            vecs[3].w[k] = 16'($urandom);
        end

        ld_en  = 1'b0;
        ld_pa  = '0;
        ld_pd  = '0;
        ld_sa  = '0;
        ld_sd  = '0;
        rst    = 1'b1;
        start  = 1'($urandom);
        dir    = 1'($urandom);
        p_base = 16'($urandom);
        s_base = 15'($urandom);
        @(negedge clk);
        start  = 1'($urandom);
        dir    = 1'($urandom);
        p_base = 16'($urandom);
        s_base = 15'($urandom);
        @(negedge clk);
        check("rst_waitTR", 32'(waitTR), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tr_p", 32'(tr_p), 32'd0);
        check("rst_tr_s", 32'(tr_s), 32'd0);
        check("rst_addr_p", 32'(addr_p), 32'd0);
        check("rst_addr_s", 32'(addr_s), 32'd0);
        check("rst_csum", 32'(csum), 32'd0);
        check("rst_data", {data_p, data_s}, 32'd0);
        rst    = 1'b0;
        start  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++) run(vecs[i], 0, 0);
        run(vecs[0], 5, 0);
        run(vecs[0], 0, 7);
        run(vecs[2], 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
